// File: rtl/fetch_stage_buffered_pkg.sv
// Shared constants and buffer-entry layout for the buffered fetch stage.
package fetch_stage_buffered_pkg;

    localparam int unsigned FETCH_INCR = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A buffer entry is {inst, pc}, so it is twice the datapath width.
    function automatic int unsigned entry_width(input int unsigned xlen);
        return 2 * xlen;
    endfunction

endpackage

// File: rtl/fetch_stage_buffered_fifo.sv
// Synchronous FIFO with flush, combinational head read and an occupancy count.
module fetch_stage_buffered_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Flush wins over any simultaneous push or pop; pop on empty is ignored.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_stage_buffered.sv
// Buffered fetch stage: credit-limited imem requests, in-order fetch buffer, redirect flush.
// Optional FETCH_MISALIGN_CHK_EN adds misalign_err and halts fetch on misaligned redirects.
module fetch_stage_buffered
    import fetch_stage_buffered_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     FB_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            b_taken,
    input  logic [XLEN-1:0] b_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_err
`endif
);

    localparam int unsigned CW = $clog2(FB_DEPTH) + 1;
    localparam int unsigned EW = entry_width(XLEN);

    logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, count;
    logic [CW+1:0]   credit_used;
    logic [EW-1:0]   head;
    logic            req_fire, resp_keep, resp_drop, pop, halted;

`ifdef FETCH_MISALIGN_CHK_EN
    logic halt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q <= 1'b0;
        end else if (b_taken) begin
            halt_q <= (b_pc[1:0] != 2'b00);
        end
    end

    assign halted       = halt_q;
    assign misalign_err = halt_q;
`else
    assign halted = 1'b0;
`endif

    // Every slot is either in the buffer, awaiting a live response or awaiting a dropped one.
    assign credit_used    = (CW+2)'(outstanding_q) + (CW+2)'(drop_cnt_q) + (CW+2)'(count);
    assign imem_req_valid = rst && !b_taken && !halted && (credit_used < (CW+2)'(FB_DEPTH));
    assign imem_req_addr  = pc_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_keep = imem_resp_valid && (drop_cnt_q == '0) && !b_taken;
    assign pop       = inst_valid && inst_ready && !b_taken;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (b_taken) begin
            pc_d          = b_pc;
            resp_pc_d     = b_pc;
            outstanding_d = '0;
            // A response landing this cycle is already stale, so it retires one in-flight slot.
            drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(imem_resp_valid);
        end else begin
            if (req_fire)  pc_d      = pc_q + XLEN'(FETCH_INCR);
            if (resp_keep) resp_pc_d = resp_pc_q + XLEN'(FETCH_INCR);
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_keep);
            drop_cnt_d    = drop_cnt_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_stage_buffered_fifo #(
        .WIDTH (EW),
        .DEPTH (FB_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_taken),
        .push      (resp_keep),
        .push_data ({imem_resp_data, resp_pc_q}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? head[EW-1 -: XLEN] : '0;
    assign pc_out     = inst_valid ? head[XLEN-1:0] : '0;

endmodule

// File: tb/tb_fetch_stage_buffered.sv
// Self-checking bench: randomized traffic against a queue-based model of the fetch stage.
module tb_fetch_stage_buffered;

    localparam int unsigned DEPTH = 4;

    logic        clk, rst, b_taken, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        inst_valid, inst_ready;
    logic [31:0] b_pc, imem_req_addr, imem_resp_data, inst_out, pc_out;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    fetch_stage_buffered #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .FB_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .b_taken         (b_taken),
        .b_pc            (b_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .pc_out          (pc_out)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_err    (misalign_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } mreq_t;

    mreq_t       mem_q[$];   // requests accepted by memory, oldest first
    logic [31:0] fifo_q[$];  // PCs the decode side should see, oldest first
    logic [31:0] exp_addr;
    bit          halt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fire;
    int p_req_ready, p_resp, p_inst_ready, p_taken;
    bit          force_taken;
    logic [31:0] force_pc;

    logic        s_req_valid, s_inst_valid, s_mis;
    logic [31:0] s_req_addr, s_pc_out;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] v;
        v = ($urandom_range(4) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
`ifdef FETCH_MISALIGN_CHK_EN
        if ($urandom_range(5) == 0) v = v | 32'h2;
`endif
        return v;
    endfunction

    // Called at a falling edge; drives, checks, updates the model, returns at the next falling edge.
    task automatic run_cycle();
        bit          taken, resp, exp_req, exp_valid;
        logic [31:0] tpc;
        mreq_t       m;
        if (force_taken) begin
            taken       = 1'b1;
            tpc         = force_pc;
            force_taken = 1'b0;
        end else begin
            taken = ($urandom_range(99) < p_taken);
            tpc   = rand_pc();
        end
        resp            = (mem_q.size() != 0) && ($urandom_range(99) < p_resp);
        b_taken         = taken;
        b_pc            = tpc;
        imem_req_ready  = ($urandom_range(99) < p_req_ready);
        inst_ready      = ($urandom_range(99) < p_inst_ready);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? memfn(mem_q[0].addr) : $urandom;
        #1;
        exp_valid = (fifo_q.size() != 0);
        exp_req   = !taken && !halt && ((mem_q.size() + fifo_q.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        chk("req_addr", imem_req_addr, exp_addr);
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("pc_out", pc_out, fifo_q[0]);
            chk("inst_out", inst_out, memfn(fifo_q[0]));
        end
`ifdef FETCH_MISALIGN_CHK_EN
        chk("misalign_err", 32'(misalign_err), 32'(halt));
        s_mis = misalign_err;
`endif
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_pc_out     = pc_out;
        if (taken) begin
            if (resp) m = mem_q.pop_front();
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            fifo_q.delete();
            exp_addr = tpc;
            halt = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            halt = (tpc[1:0] != 2'b00);
`endif
        end else begin
            if (exp_valid && inst_ready) void'(fifo_q.pop_front());
            if (resp) begin
                m = mem_q.pop_front();
                if (m.live) fifo_q.push_back(m.addr);
            end
            if (exp_req && imem_req_ready) begin
                mem_q.push_back('{exp_addr, 1'b1});
                exp_addr = exp_addr + 32'd4;
                n_fire++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        b_taken         = 1'b0;
        b_pc            = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        mem_q.delete();
        fifo_q.delete();
        exp_addr = 32'h0;
        halt     = 1'b0;
        n_fire   = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        rst = 1'b1;
    endtask

    task automatic set_probs(input int rr, input int rs, input int ir, input int tk);
        p_req_ready  = rr;
        p_resp       = rs;
        p_inst_ready = ir;
        p_taken      = tk;
    endtask

    initial begin
        logic [31:0] first_pc;
        bit          seen;
        rst         = 1'b0;
        force_taken = 1'b0;
        force_pc    = '0;
        s_mis       = 1'b0;
        @(negedge clk);

        // Streaming: one request per cycle, first instruction two cycles after release.
        do_reset();
        set_probs(100, 100, 100, 0);
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            chk("stream_addr", s_req_addr, 32'(i * 4));
            if (i < 2) begin
                chk("stream_lat", 32'(s_inst_valid), 32'h0);
            end else begin
                chk("stream_valid", 32'(s_inst_valid), 32'h1);
                chk("stream_pc", s_pc_out, 32'((i - 2) * 4));
            end
        end

        // Decode stalled: credit allows exactly FB_DEPTH requests.
        do_reset();
        set_probs(100, 100, 0, 0);
        for (int i = 0; i < 8; i++) run_cycle();
        chk("stall_fires", 32'(n_fire), 32'd4);
        chk("stall_req_valid", 32'(s_req_valid), 32'h0);
        chk("stall_full", 32'(fifo_q.size()), 32'd4);
        p_inst_ready = 100;
        run_cycle();
        chk("pop_pc", s_pc_out, 32'h0);
        p_inst_ready = 0;
        run_cycle();
        chk("refill_valid", 32'(s_req_valid), 32'h1);
        chk("refill_addr", s_req_addr, 32'd16);
        chk("refill_head", s_pc_out, 32'd4);

        // Memory back-pressure holds the address without skipping.
        set_probs(0, 100, 100, 0);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            chk("bp_addr", s_req_addr, 32'd20);
        end
        p_req_ready = 100;
        run_cycle();
        chk("bp_resume_valid", 32'(s_req_valid), 32'h1);
        chk("bp_resume_addr", s_req_addr, 32'd20);
        run_cycle();
        chk("bp_next_addr", s_req_addr, 32'd24);

        // Redirect with two requests in flight.
        do_reset();
        set_probs(100, 0, 100, 0);
        run_cycle();
        run_cycle();
        force_taken = 1'b1;
        force_pc    = 32'h100;
        run_cycle();
        p_resp = 100;
        seen   = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (s_inst_valid && !seen) begin
                seen     = 1'b1;
                first_pc = s_pc_out;
            end
        end
        chk("redir_seen", 32'(seen), 32'h1);
        chk("redir_first_pc", first_pc, 32'h100);

        // Redirect coinciding with a response and a pop.
        set_probs(100, 100, 100, 0);
        for (int i = 0; i < 6; i++) run_cycle();
        force_taken = 1'b1;
        force_pc    = 32'h300;
        run_cycle();
        chk("coinc_head_valid", 32'(s_inst_valid), 32'h1);
        run_cycle();
        chk("coinc_flushed", 32'(s_inst_valid), 32'h0);
        chk("coinc_req_valid", 32'(s_req_valid), 32'h1);
        chk("coinc_req_addr", s_req_addr, 32'h300);

`ifdef FETCH_MISALIGN_CHK_EN
        force_taken = 1'b1;
        force_pc    = 32'h102;
        run_cycle();
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            chk("mis_err", 32'(s_mis), 32'h1);
            chk("mis_halt", 32'(s_req_valid), 32'h0);
        end
        force_taken = 1'b1;
        force_pc    = 32'h200;
        run_cycle();
        run_cycle();
        chk("mis_clear", 32'(s_mis), 32'h0);
        chk("mis_resume_addr", s_req_addr, 32'h200);
        chk("mis_resume_valid", 32'(s_req_valid), 32'h1);
`endif

        // Randomized traffic, with a reset in the middle of activity.
        set_probs(70, 60, 70, 4);
        for (int i = 0; i < 1500; i++) run_cycle();
        do_reset();
        set_probs(50, 80, 40, 6);
        for (int i = 0; i < 1500; i++) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage_buffered.md
Name: fetch_stage_buffered

Overview:
- Parametrised successor to the single-cycle fetch stage. Holds the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs in an FB_DEPTH-entry fetch buffer, and hands them to decode over a valid/ready handshake.
- A taken-branch redirect flushes the buffer and discards all in-flight responses.
- Sits between the PC/branch-resolution logic and the decode stage.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- FB_DEPTH, 4, fetch-buffer entries and maximum in-flight credit (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- b_taken  in  1  redirect strobe, one cycle.
- b_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_resp_valid  in  1  response valid; always accepted; in request order.
- imem_resp_data  in  XLEN  instruction word.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  decode accepts head.
- inst_out  out  XLEN  head instruction.
- pc_out  out  XLEN  PC of head instruction.

Behaviour:
- Reset (async, rst low):
  - pc_q=RESET_PC, resp_pc=RESET_PC.
  - outstanding=0, drop_cnt=0, count=0, rd/wr pointers=0.
  - imem_req_valid=0, inst_valid=0, inst_out=0, pc_out=0.
  - Reset mid-operation abandons all state; responses arriving after reset release are not dropped (memory is reset with the core).
- Credit: imem_req_valid = !b_taken && (outstanding+drop_cnt+count) < FB_DEPTH. imem_req_addr=pc_q, driven combinationally.
- Request fire (valid&ready): pc_q<=pc_q+4, wrapping modulo 2^XLEN; outstanding+1.
- Response, drop_cnt>0: discard; drop_cnt-1.
- Response, drop_cnt==0:
  - push {imem_resp_data, resp_pc}; resp_pc<=resp_pc+4; outstanding-1.
  - Credit guarantees the push never overflows.
- Dequeue: inst_valid=(count!=0); inst_out/pc_out are the head entry (registered FIFO storage, combinational read).
  - inst_valid&inst_ready pops.
  - Push and pop in the same cycle keep count unchanged. Pop on empty is ignored.
- Minimum latency: request accepted at cycle N, response at N+1 → inst_valid at N+2.
- Redirect (b_taken=1) takes priority over every other event that cycle:
  - No request issued; no pop.
  - FIFO flushed (count=0, pointers=0).
  - pc_q<=b_pc, resp_pc<=b_pc.
  - drop_cnt <= drop_cnt + outstanding, where a response arriving this same cycle counts as dropped (subtract it from whichever counter it would have decremented).
  - outstanding<=0.
  - First request to b_pc is issued the next cycle if credit allows.
- Back-to-back redirects: each adds the then-current outstanding to drop_cnt; the last target wins.
- Counter widths: clog2(FB_DEPTH)+1 bits; all counters are bounded by FB_DEPTH.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - A redirect with b_pc[1:0]!=0 sets misalign_err and a halt flag.
  - While halted, imem_req_valid=0; the flush and drop behaviour is unchanged.
  - The next redirect with an aligned target clears both and resumes fetching.
- Undefined: no port; b_pc is used as given, and its low bits pass through to imem_req_addr.

Decomposition:
- Shared package/header (constants.vh): FETCH_INCR=4, default RESET_PC, entry layout {inst, pc} width 2*XLEN.
- One natural sub-module: fetch_fifo (parametrised sync FIFO with flush, push/pop, count output). The PC, credit and drop logic stay in the top module.

Test Plan:
- Reset, imem always ready, 1-cycle response, inst_ready=1:
  - addresses 0,4,8,12… issued every cycle.
  - pc_out=0 first valid at cycle 2 after rst release; thereafter one instruction per cycle, PCs in order.
- inst_ready=0, FB_DEPTH=4:
  - exactly 4 requests issued, then imem_req_valid=0, count=4.
  - raising inst_ready for one cycle → pc_out=0 popped, one new request (addr 16) issued.
- imem_req_ready held 0 for 3 cycles:
  - imem_req_addr stays at the same value, pc_q unchanged.
  - resumes on ready with no skipped address.
- Redirect with 2 in flight, b_pc=32'h100:
  - next 2 responses discarded; FIFO empty after flush.
  - first inst_valid carries pc_out=32'h100; no stale PC ever appears.
- Redirect coinciding with a response and an inst_ready pop:
  - response dropped, no pop counted.
  - drop_cnt equals the remaining in-flight count; next request addr = b_pc.
- FETCH_MISALIGN_CHK_EN defined, b_pc=32'h102:
  - misalign_err=1, no requests issued.
  - subsequent b_pc=32'h200 clears misalign_err and fetches 0x200.
